line_fifo: RTL and testbench

Multi-line pixel buffer for the video-stream-to-window path. It stores up to LINES_CNT complete lines of a PIXELS_PER_CLK-wide pixel stream, each with its frame and line markers. On request it replays the oldest stored line as a gap-free burst. It is the parametrised successor of the single-line buffer, adding:
- multiple line slots;
- a correct first-word line_start;
- truncation and drop handling;
- occupancy reporting.

---
 rtl/line_fifo_if.sv | 45 ++++
 rtl/line_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_line_fifo.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fifo_if.sv
// rtl/line_fifo_if.sv - pixel stream, replay request and status bundle for line_fifo
interface line_fifo_if #(
    parameter int PIXEL_WIDTH    = 12,
    parameter int PIXELS_PER_CLK = 4,
    parameter int LINES_CNT      = 4
);
    localparam int CNT_W = $clog2(LINES_CNT + 1);

    logic [PIXELS_PER_CLK*PIXEL_WIDTH-1:0] px_data_i;
    logic [PIXELS_PER_CLK-1:0]             px_data_val_i;
    logic                                  line_start_i;
    logic                                  line_end_i;
    logic                                  frame_start_i;
    logic                                  frame_end_i;
    logic                                  pop_line_i;

    logic [PIXELS_PER_CLK*PIXEL_WIDTH-1:0] px_data_o;
    logic [PIXELS_PER_CLK-1:0]             px_data_val_o;
    logic                                  line_start_o;
    logic                                  line_end_o;
    logic                                  frame_start_o;
    logic                                  frame_end_o;
    logic                                  empty_o;
    logic                                  full_o;
    logic                                  busy_o;
    logic [CNT_W-1:0]                      lines_used_o;
    logic [15:0]                           drop_cnt_o;
    logic                                  trunc_o;

    modport master (
        output px_data_i, px_data_val_i, line_start_i, line_end_i,
               frame_start_i, frame_end_i, pop_line_i,
        input  px_data_o, px_data_val_o, line_start_o, line_end_o,
               frame_start_o, frame_end_o, empty_o, full_o, busy_o,
               lines_used_o, drop_cnt_o, trunc_o
    );

    modport slave (
        input  px_data_i, px_data_val_i, line_start_i, line_end_i,
               frame_start_i, frame_end_i, pop_line_i,
        output px_data_o, px_data_val_o, line_start_o, line_end_o,
               frame_start_o, frame_end_o, empty_o, full_o, busy_o,
               lines_used_o, drop_cnt_o, trunc_o
    );
endinterface

// File: rtl/line_fifo.sv
// rtl/line_fifo.sv - multi-line pixel buffer with round-robin slots and burst replay; optional statistics under LINE_FIFO_STATS_EN
module line_fifo #(
    parameter int PIXEL_WIDTH    = 12,
    parameter int PIXELS_PER_CLK = 4,
    parameter int LINE_BUF_LIMIT = 1936,
    parameter int LINES_CNT      = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    line_fifo_if.slave bus
);
    localparam int WORDS  = (LINE_BUF_LIMIT + PIXELS_PER_CLK - 1) / PIXELS_PER_CLK;
    localparam int PTR_W  = $clog2(WORDS + 1);
    localparam int SLOT_W = (LINES_CNT > 1) ? $clog2(LINES_CNT) : 1;
    localparam int CNT_W  = $clog2(LINES_CNT + 1);
    localparam int DW     = PIXEL_WIDTH * PIXELS_PER_CLK;
    localparam int DEPTH  = LINES_CNT * WORDS;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] WORDS_P = PTR_W'(WORDS);
    localparam logic [CNT_W-1:0] SLOTS_P = CNT_W'(LINES_CNT);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
    typedef enum logic       {R_IDLE, R_READ}         r_state_t;

    logic [DW-1:0]             mem       [DEPTH];
    logic [PTR_W-1:0]          slot_len  [LINES_CNT];
    logic [PIXELS_PER_CLK-1:0] slot_mask [LINES_CNT];
    logic                      slot_sof  [LINES_CNT];
    logic                      slot_eof  [LINES_CNT];

    w_state_t         w_state, w_state_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt, mem_wptr, commit_len;
    logic [SLOT_W-1:0] wr_slot;
    logic             cur_sof, cur_sof_nxt;
    logic             wr_en, has_free, mem_we, commit;

    r_state_t          r_state, r_state_nxt;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt, rd_len;
    logic [SLOT_W-1:0] rd_slot;
    logic              issue, rd_is_last, pop_ok, free_slot;
    logic              rd_vld_q, rd_first_q, rd_last_q, rd_fs_q, rd_fe_q;
    logic [PIXELS_PER_CLK-1:0] rd_mask_q;
    logic [DW-1:0]     rd_data_q;
    logic [CNT_W-1:0]  lines_used;
    logic [ADDR_W-1:0] waddr, raddr;

    assign wr_en    = |bus.px_data_val_i;
    assign has_free = lines_used < SLOTS_P;
    assign waddr    = ADDR_W'(int'(wr_slot) * WORDS + int'(mem_wptr));
    assign raddr    = ADDR_W'(int'(rd_slot) * WORDS + int'(rd_ptr));

    // Write FSM: start, restart, fill with saturation, commit or drop a line
    always_comb begin
        w_state_nxt = w_state;
        wr_ptr_nxt  = wr_ptr;
        cur_sof_nxt = cur_sof;
        mem_we      = 1'b0;
        mem_wptr    = wr_ptr;
        commit      = 1'b0;
        commit_len  = wr_ptr;
        if (wr_en) begin
            case (w_state)
                W_IDLE, W_FILL: begin
                    if (bus.line_start_i && (w_state == W_FILL || has_free)) begin
                        mem_we      = 1'b1;
                        mem_wptr    = '0;
                        cur_sof_nxt = bus.frame_start_i;
                        if (bus.line_end_i) begin
                            commit      = 1'b1;
                            commit_len  = PTR_W'(1);
                            wr_ptr_nxt  = '0;
                            w_state_nxt = W_IDLE;
                        end else begin
                            wr_ptr_nxt  = PTR_W'(1);
                            w_state_nxt = W_FILL;
                        end
                    end else if (bus.line_start_i) begin
                        if (!bus.line_end_i) w_state_nxt = W_DROP;
                    end else if (w_state == W_FILL) begin
                        mem_we = wr_ptr < WORDS_P;
                        if (bus.line_end_i) begin
                            commit      = 1'b1;
                            commit_len  = (wr_ptr < WORDS_P) ? wr_ptr + PTR_W'(1) : WORDS_P;
                            wr_ptr_nxt  = '0;
                            w_state_nxt = W_IDLE;
                        end else if (wr_ptr < WORDS_P) begin
                            wr_ptr_nxt = wr_ptr + PTR_W'(1);
                        end
                    end
                end
                W_DROP: if (bus.line_end_i) w_state_nxt = W_IDLE;
                default: w_state_nxt = W_IDLE;
            endcase
        end
    end

    // Write-side state, slot allocation and occupancy count
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            w_state    <= W_IDLE;
            wr_ptr     <= '0;
            wr_slot    <= '0;
            cur_sof    <= 1'b0;
            lines_used <= '0;
        end else begin
            w_state <= w_state_nxt;
            wr_ptr  <= wr_ptr_nxt;
            cur_sof <= cur_sof_nxt;
            if (commit) wr_slot <= wr_slot + SLOT_W'(1);
            case ({commit, free_slot})
                2'b10:   lines_used <= lines_used + CNT_W'(1);
                2'b01:   lines_used <= lines_used - CNT_W'(1);
                default: lines_used <= lines_used;
            endcase
        end
    end

    // Pixel storage and per-slot metadata; contents need no reset
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[waddr] <= bus.px_data_i;
        if (commit) begin
            slot_len[wr_slot]  <= commit_len;
            slot_mask[wr_slot] <= bus.px_data_val_i;
            slot_sof[wr_slot]  <= cur_sof_nxt;
            slot_eof[wr_slot]  <= bus.frame_end_i;
        end
    end

    assign rd_len     = slot_len[rd_slot];
    assign rd_is_last = rd_ptr == rd_len - PTR_W'(1);
    assign bus.busy_o = (r_state == R_READ) || rd_vld_q;
    assign pop_ok     = bus.pop_line_i && (lines_used != '0) && !bus.busy_o;
    assign free_slot  = rd_vld_q && rd_last_q;

    // Read FSM: issue word addresses 0..len-1 back to back after an accepted pop
    always_comb begin
        r_state_nxt = r_state;
        rd_ptr_nxt  = rd_ptr;
        issue       = 1'b0;
        case (r_state)
            R_IDLE: if (pop_ok) begin
                r_state_nxt = R_READ;
                rd_ptr_nxt  = '0;
            end
            R_READ: begin
                issue = 1'b1;
                if (rd_is_last) begin
                    r_state_nxt = R_IDLE;
                    rd_ptr_nxt  = '0;
                end else begin
                    rd_ptr_nxt = rd_ptr + PTR_W'(1);
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read-side state plus the one-cycle output pipeline matching RAM latency
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= R_IDLE;
            rd_ptr     <= '0;
            rd_slot    <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_fs_q    <= 1'b0;
            rd_fe_q    <= 1'b0;
            rd_mask_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            r_state    <= r_state_nxt;
            rd_ptr     <= rd_ptr_nxt;
            rd_vld_q   <= issue;
            rd_first_q <= issue && (rd_ptr == '0);
            rd_last_q  <= issue && rd_is_last;
            rd_fs_q    <= issue && (rd_ptr == '0) && slot_sof[rd_slot];
            rd_fe_q    <= issue && rd_is_last && slot_eof[rd_slot];
            rd_mask_q  <= slot_mask[rd_slot];
            if (issue) rd_data_q <= mem[raddr];
            if (free_slot) rd_slot <= rd_slot + SLOT_W'(1);
        end
    end

    assign bus.px_data_o     = rd_data_q;
    assign bus.px_data_val_o = rd_vld_q ? (rd_last_q ? rd_mask_q : '1) : '0;
    assign bus.line_start_o  = rd_first_q;
    assign bus.line_end_o    = rd_last_q;
    assign bus.frame_start_o = rd_fs_q;
    assign bus.frame_end_o   = rd_fe_q;
    assign bus.empty_o       = lines_used == '0;
    assign bus.full_o        = lines_used == SLOTS_P;
    assign bus.lines_used_o  = lines_used;

`ifdef LINE_FIFO_STATS_EN
    logic        drop_evt, trunc_evt, trunc_q;
    logic [15:0] drop_cnt;

    assign drop_evt  = wr_en && (w_state == W_IDLE) && bus.line_start_i && !has_free;
    assign trunc_evt = wr_en && (w_state == W_FILL) && !bus.line_start_i && (wr_ptr == WORDS_P);

    // Saturating dropped-line counter and sticky truncation flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt <= '0;
            trunc_q  <= 1'b0;
        end else begin
            if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (trunc_evt) trunc_q <= 1'b1;
        end
    end

    assign bus.drop_cnt_o = drop_cnt;
    assign bus.trunc_o    = trunc_q;
`else
    assign bus.drop_cnt_o = '0;
    assign bus.trunc_o    = 1'b0;
`endif
endmodule

// File: tb/tb_line_fifo.sv
// tb/tb_line_fifo.sv - directed and randomized bench for line_fifo against a line-level model
module tb_line_fifo;
    localparam int W  = 4;
    localparam int NL = 2;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk_i = ~clk_i;

    line_fifo_if #(.PIXEL_WIDTH(12), .PIXELS_PER_CLK(4), .LINES_CNT(NL)) bus ();

    line_fifo #(
        .PIXEL_WIDTH(12), .PIXELS_PER_CLK(4), .LINE_BUF_LIMIT(16), .LINES_CNT(NL)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    // Line-level model: committed lines in order, the line being assembled, replay phase
    logic [47:0] st_data[$];
    int          st_len[$];
    logic [3:0]  st_mask[$];
    bit          st_sof[$];
    bit          st_eof[$];
    logic [47:0] cur_data[$];
    bit          in_line = 0, dropping = 0, cur_sof = 0, m_trunc = 0;
    int          rk = 0;
    int          m_drop = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk_i or negedge rst_n) begin
        int pre;
        if (!rst_n) begin
            st_data.delete(); st_len.delete(); st_mask.delete();
            st_sof.delete(); st_eof.delete(); cur_data.delete();
            in_line = 0; dropping = 0; cur_sof = 0; m_trunc = 0; rk = 0; m_drop = 0;
        end else begin
            pre = st_len.size();
            if (rk > 0) begin
                if (rk == st_len[0] + 1) begin
                    for (int i = 0; i < st_len[0]; i++) void'(st_data.pop_front());
                    void'(st_len.pop_front()); void'(st_mask.pop_front());
                    void'(st_sof.pop_front()); void'(st_eof.pop_front());
                    rk = 0;
                end else rk++;
            end else if (bus.pop_line_i && pre > 0) rk = 1;

            if (|bus.px_data_val_i) begin
                if (dropping) begin
                    if (bus.line_end_i) dropping = 0;
                end else begin
                    if (bus.line_start_i) begin
                        if (in_line || pre < NL) begin
                            in_line = 1;
                            cur_data.delete();
                            cur_data.push_back(bus.px_data_i);
                            cur_sof = bus.frame_start_i;
                        end else begin
                            if (m_drop < 16'hFFFF) m_drop++;
                            dropping = !bus.line_end_i;
                        end
                    end else if (in_line) begin
                        if (cur_data.size() < W) cur_data.push_back(bus.px_data_i);
                        else m_trunc = 1;
                    end
                    if (bus.line_end_i && in_line) begin
                        foreach (cur_data[i]) st_data.push_back(cur_data[i]);
                        st_len.push_back(cur_data.size());
                        st_mask.push_back(bus.px_data_val_i);
                        st_sof.push_back(cur_sof);
                        st_eof.push_back(bus.frame_end_i);
                        in_line = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk_i) begin
        if (rst_n) begin
            logic [3:0] ev;
            logic       els, ele, efs, efe;
            ev = 0; els = 0; ele = 0; efs = 0; efe = 0;
            chk("empty", bus.empty_o, st_len.size() == 0);
            chk("full", bus.full_o, st_len.size() == NL);
            chk("lines_used", bus.lines_used_o, st_len.size());
            chk("busy", bus.busy_o, rk > 0);
            if (rk >= 2) begin
                ele = (rk - 2 == st_len[0] - 1);
                els = (rk == 2);
                ev  = ele ? st_mask[0] : 4'hF;
                efs = els && st_sof[0];
                efe = ele && st_eof[0];
                chk("px_data", bus.px_data_o, st_data[rk-2]);
            end
            chk("px_val", bus.px_data_val_o, ev);
            chk("line_start", bus.line_start_o, els);
            chk("line_end", bus.line_end_o, ele);
            chk("frame_start", bus.frame_start_o, efs);
            chk("frame_end", bus.frame_end_o, efe);
`ifdef LINE_FIFO_STATS_EN
            chk("drop_cnt", bus.drop_cnt_o, m_drop);
            chk("trunc", bus.trunc_o, m_trunc);
`else
            chk("drop_cnt", bus.drop_cnt_o, 0);
            chk("trunc", bus.trunc_o, 0);
`endif
        end
    end

    task automatic drive(input logic [47:0] d, input logic [3:0] v, input logic ls, le, fs, fe, pop);
        @(negedge clk_i);
        bus.px_data_i     = d;
        bus.px_data_val_i = v;
        bus.line_start_i  = ls;
        bus.line_end_i    = le;
        bus.frame_start_i = fs;
        bus.frame_end_i   = fe;
        bus.pop_line_i    = pop;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic pop();
        drive('0, '0, 0, 0, 0, 0, 1);
    endtask

    task automatic wr_line(input int n, input logic [15:0] tag, input logic [3:0] lmask, input logic sof, eof);
        for (int i = 0; i < n; i++)
            drive({tag, 32'(i)}, (i == n - 1) ? lmask : 4'hF, i == 0, i == n - 1,
                  sof && i == 0, eof && i == n - 1, 0);
    endtask

    function automatic logic [63:0] stat_exp(input logic [63:0] v);
`ifdef LINE_FIFO_STATS_EN
        return v;
`else
        return 64'(0);
`endif
    endfunction

    initial begin
        bus.px_data_i = '0; bus.px_data_val_i = '0; bus.line_start_i = 0; bus.line_end_i = 0;
        bus.frame_start_i = 0; bus.frame_end_i = 0; bus.pop_line_i = 0;
        idle(2);
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_val", bus.px_data_val_o, 0);
        chk("rst_used", bus.lines_used_o, 0);
        @(negedge clk_i) rst_n = 1;

        // Single line with frame markers and partial last word
        wr_line(3, 16'hA001, 4'h3, 1, 1);
        pop();
        idle(1); chk("sl_busy", bus.busy_o, 1);
        idle(1); chk("sl_v0", bus.px_data_val_o, 4'hF); chk("sl_ls", bus.line_start_o, 1);
                 chk("sl_fs", bus.frame_start_o, 1); chk("sl_d0", bus.px_data_o, {16'hA001, 32'd0});
        idle(1); chk("sl_v1", bus.px_data_val_o, 4'hF);
        idle(1); chk("sl_v2", bus.px_data_val_o, 4'h3); chk("sl_le", bus.line_end_o, 1);
                 chk("sl_fe", bus.frame_end_o, 1); chk("sl_d2", bus.px_data_o, {16'hA001, 32'd2});
        idle(1); chk("sl_empty", bus.empty_o, 1);

        // Full buffer drops the third line; order kept on replay
        wr_line(2, 16'hB001, 4'hF, 1, 0);
        wr_line(2, 16'hB002, 4'h1, 0, 1);
        wr_line(4, 16'hB003, 4'hF, 0, 0);
        idle(1);
        chk("fd_full", bus.full_o, 1); chk("fd_used", bus.lines_used_o, 2);
        chk("fd_drop", bus.drop_cnt_o, stat_exp(1));
        pop(); idle(2); chk("fd_l1", bus.px_data_o, {16'hB001, 32'd0});
        idle(1); pop(); idle(2); chk("fd_l2", bus.px_data_o, {16'hB002, 32'd0});
        idle(2); chk("fd_empty", bus.empty_o, 1);

        // Truncated line replays WORDS words with the line_end mask
        wr_line(6, 16'hC001, 4'h7, 0, 0);
        pop(); idle(5);
        chk("tr_le", bus.line_end_o, 1); chk("tr_mask", bus.px_data_val_o, 4'h7);
        chk("tr_d3", bus.px_data_o, {16'hC001, 32'd3});
        chk("tr_flag", bus.trunc_o, stat_exp(1));
        idle(1); chk("tr_busy", bus.busy_o, 0);

        // Commit coinciding with last replay word, pop while busy ignored
        wr_line(2, 16'hD001, 4'hF, 0, 0);
        pop(); pop(); idle(1);
        wr_line(1, 16'hD002, 4'h5, 1, 1);
        idle(1); chk("sim_used", bus.lines_used_o, 1); chk("sim_busy", bus.busy_o, 0);
        pop(); idle(3);

        // Orphan words, then a restarted line
        drive({16'hE000, 32'd0}, 4'hF, 0, 0, 0, 0, 0);
        drive({16'hE000, 32'd1}, 4'hF, 0, 1, 0, 0, 0);
        idle(1); chk("or_empty", bus.empty_o, 1);
        drive({16'hE001, 32'd0}, 4'hF, 1, 0, 0, 0, 0);
        drive({16'hE001, 32'd1}, 4'hF, 0, 0, 0, 0, 0);
        wr_line(3, 16'hE002, 4'hF, 0, 0);
        pop(); idle(4);
        chk("or_le", bus.line_end_o, 1); chk("or_d2", bus.px_data_o, {16'hE002, 32'd2});
        idle(1); chk("or_empty2", bus.empty_o, 1);

        // Reset in the middle of a replay
        wr_line(3, 16'hF001, 4'hF, 1, 1);
        pop(); idle(2);
        @(posedge clk_i); #1 rst_n = 0; #1;
        chk("mr_busy", bus.busy_o, 0); chk("mr_val", bus.px_data_val_o, 0);
        chk("mr_ls", bus.line_start_o, 0); chk("mr_fs", bus.frame_start_o, 0);
        chk("mr_empty", bus.empty_o, 1); chk("mr_used", bus.lines_used_o, 0);
        chk("mr_data", bus.px_data_o, 0);
        @(negedge clk_i) rst_n = 1;
        idle(1);
        wr_line(1, 16'hF002, 4'h9, 1, 0);
        pop(); idle(2);
        chk("ar_d", bus.px_data_o, {16'hF002, 32'd0}); chk("ar_val", bus.px_data_val_o, 4'h9);
        chk("ar_ls", bus.line_start_o, 1); chk("ar_le", bus.line_end_o, 1);
        idle(2);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive({16'($urandom), $urandom},
                  ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
